// File: rtl/reg_wb_pkg.sv
// Shared constants and types for the register-file write-back path.
// Scoreboard features are selected elsewhere with REG_WB_SCOREBOARD_EN.
package reg_wb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] sel;
        logic [DATA_W_DEF-1:0] val;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr,
// plus the pointer value that makes the winner's successor highest priority.
module rr_arbiter #(
    parameter int N = 3,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] next_ptr
);

    int idx;

    // Walk from the lowest priority to the highest so the last hit wins.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        idx      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                next_ptr   = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter for the register file write port, with an optional
// outstanding-write scoreboard enabled by REG_WB_SCOREBOARD_EN.
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int N_SRC  = 3,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_SRC-1:0]          src_valid,
    output logic [N_SRC-1:0]          src_ready,
    input  logic [N_SRC*ADDR_W-1:0]   src_sel,
    input  logic [N_SRC*DATA_W-1:0]   src_val,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_sel,
    output logic [DATA_W-1:0]         rf_val,
    input  logic                      issue_valid,
    input  logic [ADDR_W-1:0]         issue_sel,
    input  logic [ADDR_W-1:0]         rd_sel_1,
    input  logic [ADDR_W-1:0]         rd_sel_2,
    output logic                      busy_1,
    output logic                      busy_2,
    output logic [(2**ADDR_W)-1:0]    busy_mask,
    output logic                      sb_err
);

    localparam int PTR_W = $clog2(N_SRC);
    localparam int N_REG = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(REG_ZERO);

    // Handshake: a transfer on source i happens in a cycle where
    // src_valid[i] && src_ready[i]; ready never feeds back into valid.
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  next_ptr;
    logic [N_SRC-1:0]  grant;
    logic              accept;
    logic [ADDR_W-1:0] win_sel;
    logic [DATA_W-1:0] win_val;

    rr_arbiter #(.N(N_SRC)) u_rr (
        .req      (src_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .next_ptr (next_ptr)
    );

    assign src_ready = rst_n ? grant : '0;
    assign accept    = |grant;

    always_comb begin
        win_sel = '0;
        win_val = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant[i]) begin
                win_sel = src_sel[i*ADDR_W +: ADDR_W];
                win_val = src_val[i*DATA_W +: DATA_W];
            end
        end
    end

    // Writes to register 0 are consumed but never reach the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            rf_we  <= 1'b0;
            rf_sel <= '0;
            rf_val <= '0;
        end else begin
            rf_we <= accept && (win_sel != ZERO_SEL);
            if (accept) begin
                rr_ptr <= next_ptr;
                rf_sel <= win_sel;
                rf_val <= win_val;
            end
        end
    end

`ifdef REG_WB_SCOREBOARD_EN
    logic [N_REG-1:0] busy_q;
    logic [N_REG-1:0] set_vec;
    logic [N_REG-1:0] clr_vec;
    logic             waw;

    // A register retiring on the same edge as a new issue is not a WAW hit.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid && (issue_sel != ZERO_SEL)) set_vec[issue_sel] = 1'b1;
        if (rf_we) clr_vec[rf_sel] = 1'b1;
        waw = |(set_vec & busy_q & ~clr_vec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            sb_err <= 1'b0;
        end else begin
            busy_q <= (busy_q & ~clr_vec) | set_vec;
            sb_err <= sb_err | waw;
        end
    end

    assign busy_mask = busy_q;
    assign busy_1    = busy_q[rd_sel_1];
    assign busy_2    = busy_q[rd_sel_2];
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{issue_valid, issue_sel, rd_sel_1, rd_sel_2};

    assign busy_mask = '0;
    assign busy_1    = 1'b0;
    assign busy_2    = 1'b0;
    assign sb_err    = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed plus randomized bench for reg_wb_arbiter against a behavioural model.
module tb_reg_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef REG_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    src_valid;
  logic [N-1:0]    src_ready;
  logic [N*AW-1:0] src_sel;
  logic [N*DW-1:0] src_val;
  logic            rf_we;
  logic [AW-1:0]   rf_sel;
  logic [DW-1:0]   rf_val;
  logic            issue_valid;
  logic [AW-1:0]   issue_sel;
  logic [AW-1:0]   rd_sel_1;
  logic [AW-1:0]   rd_sel_2;
  logic            busy_1;
  logic            busy_2;
  logic [31:0]     busy_mask;
  logic            sb_err;

  reg_wb_arbiter #(.N_SRC(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_sel     (src_sel),
    .src_val     (src_val),
    .rf_we       (rf_we),
    .rf_sel      (rf_sel),
    .rf_val      (rf_val),
    .issue_valid (issue_valid),
    .issue_sel   (issue_sel),
    .rd_sel_1    (rd_sel_1),
    .rd_sel_2    (rd_sel_2),
    .busy_1      (busy_1),
    .busy_2      (busy_2),
    .busy_mask   (busy_mask),
    .sb_err      (sb_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  // reference model state
  int               m_ptr;
  int               m_g;
  bit               m_busy[32];
  bit               m_err;
  bit               last_we;
  logic [AW-1:0]    last_sel;
  logic [AW+DW-1:0] exp_q[$];

  // values sampled at the last check point
  logic [N-1:0]  s_ready;
  logic          s_we;
  logic [AW-1:0] s_sel;
  logic [DW-1:0] s_val;
  logic          s_b1;
  logic          s_b2;
  logic          s_err;
  logic [31:0]   s_mask;

  int order[6];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_g     = -1;
    m_err   = 1'b0;
    last_we = 1'b0;
    last_sel = '0;
    for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    for (int r = 0; r < 32; r++) m[r] = m_busy[r];
    return m;
  endfunction

  // driver tasks
  task automatic set_src(input int i, input bit v, input logic [AW-1:0] sel, input logic [DW-1:0] val);
    src_valid[i]        = v;
    src_sel[i*AW +: AW] = sel;
    src_val[i*DW +: DW] = val;
  endtask

  // Sample and compare everything on the falling edge.
  task automatic check_phase();
    logic [N-1:0]     er;
    logic [AW+DW-1:0] e;
    @(negedge clk);
    if (!rst_n) model_reset();
    m_g = -1;
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        if (m_g < 0 && src_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
      end
    end
    s_ready = src_ready; s_we = rf_we; s_sel = rf_sel; s_val = rf_val;
    s_b1 = busy_1; s_b2 = busy_2; s_err = sb_err; s_mask = busy_mask;
    er = '0;
    if (m_g >= 0) er[m_g] = 1'b1;
    chk("src_ready", s_ready, er);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rf_we", s_we, 1);
      chk("rf_sel", s_sel, e[AW+DW-1:DW]);
      chk("rf_val", s_val, e[DW-1:0]);
      last_we  = 1'b1;
      last_sel = e[AW+DW-1:DW];
    end else begin
      chk("rf_we_idle", s_we, 0);
      last_we = 1'b0;
    end
    chk("busy_mask", s_mask, SB ? model_mask() : 32'h0);
    chk("busy_1", s_b1, SB & m_busy[rd_sel_1]);
    chk("busy_2", s_b2, SB & m_busy[rd_sel_2]);
    chk("sb_err", s_err, SB & m_err);
  endtask

  // Advance the model across the rising edge, then leave room for drivers.
  task automatic edge_phase();
    logic [AW-1:0] s;
    logic [AW-1:0] gsel;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      s = issue_sel;
      if (issue_valid && s != 0 && m_busy[s] && !(last_we && last_sel == s)) m_err = 1'b1;
      if (last_we) m_busy[last_sel] = 1'b0;
      if (issue_valid && s != 0) m_busy[s] = 1'b1;
      if (m_g >= 0) begin
        m_ptr = (m_g + 1) % N;
        gsel  = src_sel[m_g*AW +: AW];
        if (gsel != 0) exp_q.push_back({gsel, src_val[m_g*DW +: DW]});
      end
    end
    #1;
  endtask

  task automatic cycle();
    check_phase();
    edge_phase();
  endtask

  initial begin
    int g;
    n_chk = 0;
    n_err = 0;
    model_reset();
    rst_n = 1'b0;
    src_valid = '1; src_sel = '0; src_val = '0;
    issue_valid = 1'b0; issue_sel = '0; rd_sel_1 = '0; rd_sel_2 = '0;

    // reset state, with every source requesting
    cycle();
    cycle();
    chk("reset_ready", s_ready, 0);
    chk("reset_rf_we", s_we, 0);
    chk("reset_rf_sel", s_sel, 0);
    chk("reset_rf_val", s_val, 0);
    chk("reset_mask", s_mask, 0);
    src_valid = '0;
    rst_n = 1'b1;

    // single source
    set_src(1, 1, 5'd8, 32'hDEADBEEF);
    check_phase();
    chk("single_ready", s_ready, 3'b010);
    edge_phase();
    src_valid = '0;
    cycle();
    chk("single_we", s_we, 1);
    chk("single_sel", s_sel, 8);
    chk("single_val", s_val, 32'hDEADBEEF);
    cycle();
    chk("single_we_drop", s_we, 0);

    // full contention from pointer 0
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_src(i, 1, AW'(10 + i), 32'h100 + i);
    for (int c = 0; c < 6; c++) begin
      check_phase();
      order[c] = m_g;
      if (c > 0) chk("cont_we", s_we, 1);
      for (int i = 0; i < N; i++) if (s_ready[i]) order[c] = i;
      edge_phase();
      if (order[c] >= 0) set_src(order[c], 1, AW'(16 + c), 32'h200 + c);
    end
    src_valid = '0;
    cycle();
    chk("cont_we_last", s_we, 1);
    cycle();
    chk("cont_we_drop", s_we, 0);
    for (int c = 0; c < 6; c++) chk($sformatf("cont_order%0d", c), order[c], c % N);

    // register 0 write is consumed silently and advances the pointer
    set_src(0, 1, 5'd0, 32'h12345678);
    check_phase();
    chk("reg0_ready", s_ready, 3'b001);
    edge_phase();
    src_valid = '0;
    cycle();
    chk("reg0_no_we", s_we, 0);
    set_src(0, 1, 5'd3, 32'h33);
    set_src(1, 1, 5'd4, 32'h44);
    check_phase();
    chk("reg0_ptr_adv", s_ready, 3'b010);
    edge_phase();
    src_valid = '0;
    cycle();

    // scoreboard set / clear
    rd_sel_1 = 5'd5;
    issue_valid = 1'b1; issue_sel = 5'd5;
    cycle();
    issue_valid = 1'b0;
    cycle();
    chk("sb_busy_set", s_b1, SB);
    set_src(2, 1, 5'd5, 32'h55);
    cycle();
    src_valid = '0;
    cycle();
    chk("sb_port_we", s_we, 1);
    chk("sb_no_bypass", s_b1, SB);
    cycle();
    chk("sb_busy_clear", s_b1, 0);

    // same-edge issue and retire keeps the bit
    issue_valid = 1'b1; issue_sel = 5'd5;
    cycle();
    issue_valid = 1'b0;
    set_src(0, 1, 5'd5, 32'h5A);
    cycle();
    src_valid = '0;
    issue_valid = 1'b1; issue_sel = 5'd5;
    cycle();
    issue_valid = 1'b0;
    cycle();
    chk("sb_same_edge", s_b1, SB);
    set_src(1, 1, 5'd5, 32'h5B);
    cycle();
    src_valid = '0;
    cycle();
    cycle();
    chk("sb_retired", s_b1, 0);

    // WAW error is sticky
    rd_sel_2 = 5'd7;
    issue_valid = 1'b1; issue_sel = 5'd7;
    cycle();
    cycle();
    issue_valid = 1'b0;
    cycle();
    chk("waw_err", s_err, SB);
    chk("waw_busy2", s_b2, SB);
    repeat (3) cycle();
    chk("waw_sticky", s_err, SB);

    // reset while a write sits between acceptance and the port
    set_src(1, 1, 5'd9, 32'h99);
    check_phase();
    chk("midrst_ready", s_ready, 3'b010);
    #1 rst_n = 1'b0;
    edge_phase();
    src_valid = '0;
    check_phase();
    chk("midrst_we", s_we, 0);
    chk("midrst_err", s_err, 0);
    chk("midrst_mask", s_mask, 0);
    edge_phase();
    rst_n = 1'b1;
    cycle();
    chk("midrst_no_write", s_we, 0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!src_valid[i] && $urandom_range(0, 1) == 1)
          set_src(i, 1, AW'($urandom_range(0, 31)), $urandom());
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_sel   = AW'($urandom_range(0, 31));
      rd_sel_1    = AW'($urandom_range(0, 31));
      rd_sel_2    = AW'($urandom_range(0, 31));
      check_phase();
      g = m_g;
      edge_phase();
      if (g >= 0) src_valid[g] = 1'b0;
    end
    src_valid = '0;
    issue_valid = 1'b0;
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
